// File: rtl/zir_pkg.sv
// Shared definitions for the IR capture run controller: the state encoding and
// the 48 MHz cycle-count constants used for the power-on delay and the frame watchdog.
package zir_pkg;

    typedef enum logic [2:0] {
        ST_DELAY    = 3'd0,
        ST_REQ      = 3'd1,
        ST_RUN      = 3'd2,
        ST_DONE     = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_HALT     = 3'd5
    } zir_state_t;

    localparam int unsigned CLK_HZ              = 48_000_000;
    localparam logic [31:0] POR_DELAY_1S        = 32'(CLK_HZ);
    localparam logic [23:0] FRAME_TIMEOUT_250MS = 24'(CLK_HZ / 4);

endpackage

// File: rtl/zir_pclk_sim.sv
// Free-running pixel-clock stand-in for sensor-less bring-up: oPCLK toggles
// every DIV enabled iClk cycles, so its period is 2*DIV cycles.
module zir_pclk_sim #(
    parameter int unsigned DIV = 5
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iEn,
    output logic oPCLK
);

    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt   <= '0;
            oPCLK <= 1'b0;
        end else if (iEn) begin
            if (cnt == LAST) begin
                cnt   <= '0;
                oPCLK <= ~oPCLK;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/zir_capture_sequencer.sv
// IR capture run controller: power-on delay, StoreFPGA write request, N-frame (or
// continuous) capture with per-frame watchdog, then oWr_Done/iStore_Ack handshake.
// Optional simulated pixel clock on oPCLK_Sim when ZIR_PCLK_SIM_EN is defined.
module zir_capture_sequencer
    import zir_pkg::*;
#(
    parameter int unsigned        DELAY_W       = 32,
    parameter logic [DELAY_W-1:0] POR_DELAY     = DELAY_W'(POR_DELAY_1S),
    parameter int unsigned        REQ_CYCLES    = 6,
    parameter int unsigned        FRAMES        = 1,
    parameter int unsigned        TMO_W         = 24,
    parameter logic [TMO_W-1:0]   FRAME_TIMEOUT = TMO_W'(FRAME_TIMEOUT_250MS),
    parameter int unsigned        PCLK_DIV      = 5
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    input  logic        iWr_Frame_Done,
    input  logic        iStore_Ack,
    output logic        oCapture_En,
    output logic        oDDRWriter_En,
    output logic        oWr_Req,
    output logic        oWr_Done,
    output logic        oBusy,
    output logic        oTimeout,
    output logic [15:0] oFrame_Cnt,
    output logic        oPCLK_Sim
);

    localparam logic [7:0] REQ_LAST = 8'(REQ_CYCLES - 1);

    zir_state_t         state, state_nxt;
    logic [DELAY_W-1:0] delay_cnt;
    logic [7:0]         req_cnt;
    logic [TMO_W-1:0]   wdog_cnt;

    logic               delay_last, req_last, frame_last, wdog_expire, run_frame;
    logic [15:0]        frame_inc;
    logic [TMO_W-1:0]   wdog_inc;

    logic               en_nxt, req_nxt, done_nxt, busy_nxt, timeout_nxt;

    always_comb begin
        delay_last  = (delay_cnt == POR_DELAY - DELAY_W'(1));
        req_last    = (req_cnt == REQ_LAST);
        run_frame   = (state == ST_RUN) && iWr_Frame_Done;
        frame_inc   = oFrame_Cnt + 16'd1;
        frame_last  = (FRAMES != 0) && (frame_inc == 16'(FRAMES));
        wdog_inc    = wdog_cnt + TMO_W'(1);
        // A frame-done in the expiry cycle wins over the watchdog.
        wdog_expire = (FRAME_TIMEOUT != '0) && !iWr_Frame_Done && (wdog_inc == FRAME_TIMEOUT);
    end

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= ST_DELAY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_DELAY:    if (delay_last) state_nxt = ST_REQ;
            ST_REQ:      if (req_last)   state_nxt = ST_RUN;
            ST_RUN: begin
                if (iWr_Frame_Done && frame_last) begin
                    state_nxt = ST_DONE;
                end else if (wdog_expire) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_DONE:     state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: if (iStore_Ack) state_nxt = ST_HALT;
            ST_HALT:     if (iStart)     state_nxt = ST_REQ;
            default:     state_nxt = ST_DELAY;
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from the next state
    always_comb begin
        en_nxt      = (state_nxt == ST_RUN) && !run_frame;
        req_nxt     = (state_nxt == ST_REQ);
        done_nxt    = (state_nxt == ST_DONE) || (state_nxt == ST_WAIT_ACK);
        busy_nxt    = (state_nxt != ST_HALT);
        timeout_nxt = oTimeout;
        if ((state == ST_HALT) && iStart) begin
            timeout_nxt = 1'b0;
        end else if ((state == ST_RUN) && wdog_expire) begin
            timeout_nxt = 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oCapture_En   <= 1'b0;
            oDDRWriter_En <= 1'b0;
            oWr_Req       <= 1'b0;
            oWr_Done      <= 1'b0;
            oBusy         <= 1'b0;
            oTimeout      <= 1'b0;
        end else begin
            oCapture_En   <= en_nxt;
            oDDRWriter_En <= en_nxt;
            oWr_Req       <= req_nxt;
            oWr_Done      <= done_nxt;
            oBusy         <= busy_nxt;
            oTimeout      <= timeout_nxt;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            delay_cnt  <= '0;
            req_cnt    <= '0;
            wdog_cnt   <= '0;
            oFrame_Cnt <= '0;
        end else begin
            delay_cnt <= ((state == ST_DELAY) && !delay_last) ? delay_cnt + DELAY_W'(1) : '0;
            req_cnt   <= ((state == ST_REQ) && !req_last) ? req_cnt + 8'd1 : '0;
            wdog_cnt  <= ((state == ST_RUN) && !iWr_Frame_Done && (FRAME_TIMEOUT != '0) && !wdog_expire)
                         ? wdog_inc : '0;
            if (run_frame) begin
                oFrame_Cnt <= frame_inc;
            end else if ((state == ST_HALT) && iStart) begin
                oFrame_Cnt <= '0;
            end
        end
    end

`ifdef ZIR_PCLK_SIM_EN
    zir_pclk_sim #(
        .DIV (PCLK_DIV)
    ) u_pclk_sim (
        .iClk  (iClk),
        .iRst  (iRst),
        .iEn   (state != ST_DELAY),
        .oPCLK (oPCLK_Sim)
    );
`else
    logic pclk_div_unused;
    assign pclk_div_unused = (PCLK_DIV == 0);
    assign oPCLK_Sim       = 1'b0;
`endif

endmodule

// File: tb/tb_zir_capture_sequencer.sv
// Self-checking bench for zir_capture_sequencer with randomized frame spacing,
// ack delays and ignored-input noise; expectations come from cycle arithmetic.
module tb_zir_capture_sequencer;

    localparam int P_POR    = 100;
    localparam int P_REQ    = 6;
    localparam int P_FRAMES = 3;
    localparam int P_TMO    = 500;
    localparam int P_DIV    = 5;

    logic        clk = 1'b0;
    logic        rst, start, fdone, ack;
    logic        cap_en, ddr_en, wr_req, wr_done, busy, tmo, pclk;
    logic [15:0] fcnt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    zir_capture_sequencer #(
        .DELAY_W       (32),
        .POR_DELAY     (32'(P_POR)),
        .REQ_CYCLES    (P_REQ),
        .FRAMES        (P_FRAMES),
        .TMO_W         (24),
        .FRAME_TIMEOUT (24'(P_TMO)),
        .PCLK_DIV      (P_DIV)
    ) dut (
        .iClk           (clk),
        .iRst           (rst),
        .iStart         (start),
        .iWr_Frame_Done (fdone),
        .iStore_Ack     (ack),
        .oCapture_En    (cap_en),
        .oDDRWriter_En  (ddr_en),
        .oWr_Req        (wr_req),
        .oWr_Done       (wr_done),
        .oBusy          (busy),
        .oTimeout       (tmo),
        .oFrame_Cnt     (fcnt),
        .oPCLK_Sim      (pclk)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_en(input string tag, input logic exp);
        check({tag, "_cap"}, cap_en, exp);
        check({tag, "_ddr"}, ddr_en, exp);
    endtask

    // Edge e after reset release: request during edges P_POR..P_POR+P_REQ-1, enables from P_POR+P_REQ
    task automatic expect_por();
        for (int e = 1; e <= P_POR + P_REQ; e++) begin
            tick();
            check("por_req", wr_req, (e >= P_POR) && (e < P_POR + P_REQ));
            check_en("por_en", e == P_POR + P_REQ);
            check("por_busy", busy, 1'b1);
            if (e < P_POR) check("por_pclk", pclk, 1'b0);
        end
        check("por_cnt", fcnt, 0);
        check("por_done", wr_done, 1'b0);
    endtask

    task automatic expect_req();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_cnt", fcnt, 0);
        check("rst_tmo", tmo, 1'b0);
        check("rst_busy", busy, 1'b1);
        for (int i = 0; i <= P_REQ; i++) begin
            if (i > 0) tick();
            check("req_pulse", wr_req, i < P_REQ);
            check_en("req_en", i == P_REQ);
        end
    endtask

    // RUN cycles with no frame-done; iStart/iStore_Ack noise must be ignored
    task automatic idle_run(input int n, input int exp_cnt);
        for (int i = 0; i < n; i++) begin
            start = 1'($urandom_range(0, 1));
            ack   = 1'($urandom_range(0, 1));
            tick();
            check_en("run_en", 1'b1);
            check("run_cnt", fcnt, exp_cnt);
            check("run_tmo", tmo, 1'b0);
            check("run_done", wr_done, 1'b0);
        end
        start = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic frame_pulse(input int k, input bit last);
        fdone = 1'b1;
        tick();
        fdone = 1'b0;
        check("fr_cnt", fcnt, k);
        check_en("fr_gap", 1'b0);
        check("fr_tmo", tmo, 1'b0);
        check("fr_done", wr_done, last);
        if (!last) begin
            tick();
            check_en("fr_rearm", 1'b1);
            check("fr_cnt_hold", fcnt, k);
        end
    endtask

    task automatic wait_ack(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("ack_done_hold", wr_done, 1'b1);
            check("ack_busy", busy, 1'b1);
            check_en("ack_en", 1'b0);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_done_fall", wr_done, 1'b0);
        check("ack_busy_fall", busy, 1'b0);
        check("ack_cnt", fcnt, P_FRAMES);
    endtask

    task automatic random_frames();
        for (int k = 1; k <= P_FRAMES; k++) begin
            idle_run($urandom_range(150, 250), k - 1);
            frame_pulse(k, k == P_FRAMES);
        end
    endtask

    task automatic pclk_check();
`ifdef ZIR_PCLK_SIM_EN
        int   last = -1;
        int   nt   = 0;
        logic prev = pclk;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (pclk !== prev) begin
                if (last >= 0) check("pclk_half", i - last, P_DIV);
                last = i;
                nt++;
            end
            prev = pclk;
        end
        check("pclk_toggles", nt, 40 / P_DIV);
`else
        int ones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pclk !== 1'b0) ones++;
        end
        check("pclk_const0", ones, 0);
`endif
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fdone = 1'b0;
        ack   = 1'b0;
        #23;
        check("rst_outs", {cap_en, ddr_en, wr_req, wr_done, busy, tmo, pclk}, 0);
        check("rst_fcnt", fcnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Run A: power-on sequence, three randomly spaced frames, long ack stall
        expect_por();
        random_frames();
        wait_ack(50);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halt_busy", busy, 1'b0);
            check("halt_done", wr_done, 1'b0);
            check("halt_cnt", fcnt, P_FRAMES);
            check_en("halt_en", 1'b0);
        end
        pclk_check();

        // Run B: frame-done coinciding with watchdog expiry, back-to-back pulse in gap, then timeout
        expect_req();
        idle_run(P_TMO - 1, 0);
        fdone = 1'b1;
        tick();
        check("coll_cnt", fcnt, 1);
        check("coll_tmo", tmo, 1'b0);
        check_en("coll_gap", 1'b0);
        tick();
        fdone = 1'b0;
        check("gap_pulse_cnt", fcnt, 2);
        check_en("gap_pulse_en", 1'b0);
        tick();
        check_en("gap_pulse_rearm", 1'b1);
        idle_run(P_TMO - 2, 2);
        tick();
        check("tmo_flag", tmo, 1'b1);
        check_en("tmo_en", 1'b0);
        check("tmo_busy", busy, 1'b0);
        check("tmo_done", wr_done, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("tmo_ack_ign", busy, 1'b0);
        check("tmo_sticky", tmo, 1'b1);
        check("tmo_done2", wr_done, 1'b0);
        check("tmo_cnt", fcnt, 2);

        // Run C: restart from HALT without the power-on delay, random frames and ack delay
        expect_req();
        random_frames();
        wait_ack($urandom_range(1, 60));

        // Run D: asynchronous reset in the middle of RUN, then full restart
        expect_req();
        idle_run($urandom_range(10, 100), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_en("async_rst_en", 1'b0);
        check("async_rst_busy", busy, 1'b0);
        #10;
        @(negedge clk);
        rst = 1'b0;
        expect_por();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
